// File: rtl/muldiv_ctrl_if.sv
// Operand, handshake and result bundle between the EX stage and the
// multiply/divide sequencer.
interface muldiv_ctrl_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output stall, done, result
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// RV32M multi-cycle sequencer: 32-step shift-add multiply and restoring
// divide on operand magnitudes, with signs applied in a final fix-up step.
module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_ctrl_if.slave bus
);
    localparam int              W2       = 2 * XLEN;
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_e;

    state_e          state_q;
    logic [5:0]      cnt_q;
    logic [W2-1:0]   acc_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] result_q;
    logic            neg_res_q;
    logic            neg_rem_q;
    logic            done_q;

    logic            aSigned_d;
    logic            bSigned_d;
    logic            signA_d;
    logic            signB_d;
    logic [XLEN-1:0] aMag_d;
    logic [XLEN-1:0] bMag_d;
    logic [XLEN:0]   mulSum_d;
    logic [W2-1:0]   mulStep_d;
    logic            divGeq_d;
    logic [XLEN-1:0] divDiff_d;
    logic [W2-1:0]   divStep_d;
    logic [W2-1:0]   prod_d;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] fixResult_d;
    logic            divByZero_d;
    logic            overflow_d;
    logic [XLEN-1:0] specialResult_d;

    always_comb begin
        aSigned_d = (funct3_q == 3'b001) || (funct3_q == 3'b010) ||
                    (funct3_q == 3'b100) || (funct3_q == 3'b110);
        bSigned_d = (funct3_q == 3'b001) || (funct3_q == 3'b100) ||
                    (funct3_q == 3'b110);
        signA_d   = aSigned_d && a_q[XLEN-1];
        signB_d   = bSigned_d && b_q[XLEN-1];
        aMag_d    = signA_d ? ('0 - a_q) : a_q;
        bMag_d    = signB_d ? ('0 - b_q) : b_q;

        // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
        mulSum_d  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mulStep_d = {mulSum_d, acc_q[XLEN-1:1]};
        divGeq_d  = acc_q[W2-1:XLEN-1] >= {1'b0, b_q};
        divDiff_d = acc_q[W2-2:XLEN-1] - b_q;
        divStep_d = divGeq_d ? {divDiff_d, acc_q[XLEN-2:0], 1'b1}
                             : {acc_q[W2-2:0], 1'b0};

        prod_d = neg_res_q ? ('0 - acc_q) : acc_q;
        quo_d  = neg_res_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem_d  = neg_rem_q ? ('0 - acc_q[W2-1:XLEN]) : acc_q[W2-1:XLEN];
        case (funct3_q)
            3'b000:                 fixResult_d = prod_d[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fixResult_d = prod_d[W2-1:XLEN];
            3'b100, 3'b101:         fixResult_d = quo_d;
            default:                fixResult_d = rem_d;
        endcase

        // Divide-by-zero and signed overflow finish without iterating
        divByZero_d = bus.funct3[2] && (bus.op_b == '0);
        overflow_d  = bus.funct3[2] && !bus.funct3[0] &&
                      (bus.op_a == INT_MIN) && (bus.op_b == ALL_ONES);
        if (divByZero_d) begin
            specialResult_d = bus.funct3[1] ? bus.op_a : ALL_ONES;
        end else begin
            specialResult_d = bus.funct3[1] ? '0 : INT_MIN;
        end
    end

    assign bus.stall  = !rst && !bus.flush &&
                        (((state_q == IDLE) && bus.start) ||
                         (state_q inside {PREP, RUN, FIX}));
    assign bus.done   = done_q;
    assign bus.result = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            funct3_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        funct3_q <= bus.funct3;
                        a_q      <= bus.op_a;
                        b_q      <= bus.op_b;
                        if (divByZero_d || overflow_d) begin
                            result_q <= specialResult_d;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q <= PREP;
                        end
                    end
                end
                PREP: begin
                    a_q       <= aMag_d;
                    b_q       <= bMag_d;
                    neg_res_q <= signA_d ^ signB_d;
                    neg_rem_q <= signA_d;
                    acc_q     <= {{XLEN{1'b0}}, aMag_d};
                    cnt_q     <= '0;
                    state_q   <= RUN;
                end
                RUN: begin
                    acc_q <= funct3_q[2] ? divStep_d : mulStep_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fixResult_d;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed RV32M vectors, result/latency/stall
// expectations queued at issue and checked by an independent done monitor.
module tb_muldiv_ctrl;
    typedef struct {
        string       name;
        logic [31:0] result;
        int          doneCycle;
        int          stalls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cycleCnt   = 0;
    int          stallRun   = 0;
    logic [31:0] lastResult = 32'd0;

    muldiv_ctrl_if #(.XLEN(32)) bus ();

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one op; lat is both the done latency and the number of stall cycles
    task automatic applyStimulus(input string name, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expResult, input int lat);
        exp_t e;
        bit   got;
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.flush  = 1'b0;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        e.name      = name;
        e.result    = expResult;
        e.doneCycle = cycleCnt + lat;
        e.stalls    = lat;
        sb.push_back(e);
        lastResult = expResult;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s timeout: no done within 100 cycles", name);
            void'(sb.pop_back());
        end
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Monitor: pops an expectation on every done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stallRun = 0;
            end else if (bus.done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected done", {31'd0, bus.done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, " result"}, bus.result, e.result);
                    checkOutput({e.name, " done cycle"}, 32'(cycleCnt), 32'(e.doneCycle));
                    checkOutput({e.name, " stall cycles"}, 32'(stallRun), 32'(e.stalls));
                end
                stallRun = 0;
            end else if (bus.stall) begin
                stallRun++;
            end else begin
                stallRun = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'b000;
        bus.op_a   = 32'd0;
        bus.op_b   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        #1;
        checkOutput("stall gated by reset", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        checkOutput("reset result", bus.result, 32'd0);
        checkOutput("reset done", {31'd0, bus.done}, 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst       = 1'b0;

        // Back-to-back MUL then DIV: done pulses 36 cycles apart
        applyStimulus("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        applyStimulus("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
        idleCycle();
        applyStimulus("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
        applyStimulus("MULHSU min*2^31", 3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 35);
        applyStimulus("MULHU 2^31*2^31", 3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
        applyStimulus("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        applyStimulus("MUL wrap", 3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 35);
        applyStimulus("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
        applyStimulus("DIVU big/2", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 35);
        applyStimulus("REMU big/2", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 35);
        applyStimulus("DIV 100/-7", 3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 35);
        applyStimulus("REM 100/-7", 3'b110, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 35);
        applyStimulus("DIV min/1", 3'b100, 32'h8000_0000, 32'd1, 32'h8000_0000, 35);
        applyStimulus("DIVU min/-1", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 35);
        idleCycle();

        // Special cases complete in one stall cycle
        applyStimulus("DIVU 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        applyStimulus("REM 5/0", 3'b110, 32'd5, 32'd0, 32'h0000_0005, 1);
        applyStimulus("DIV min/-1", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        applyStimulus("REM min/-1", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        applyStimulus("REMU x/0", 3'b111, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        applyStimulus("DIV 0/0", 3'b100, 32'd0, 32'd0, 32'hFFFF_FFFF, 1);
        idleCycle();

        // Flush during RUN iteration 10
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.op_a   = 32'd5;
        bus.op_b   = 32'd6;
        repeat (12) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        #1;
        checkOutput("stall drops on flush", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        checkOutput("result kept on flush", bus.result, lastResult);
        applyStimulus("MUL after flush", 3'b000, 32'd1000, 32'd1000, 32'h000F_4240, 35);
        idleCycle();

        // Reset pulse in the middle of RUN
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.funct3 = 3'b101;
        bus.op_a   = 32'd99;
        bus.op_b   = 32'd9;
        repeat (15) @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.start = 1'b0;
        #1;
        checkOutput("stall low in reset", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("result after reset", bus.result, 32'd0);
        checkOutput("done after reset", {31'd0, bus.done}, 32'd0);
        checkOutput("stall after reset", {31'd0, bus.stall}, 32'd0);
        rst = 1'b0;
        applyStimulus("DIVU after reset", 3'b101, 32'd99, 32'd9, 32'd11, 35);
        idleCycle();

        repeat (5) @(posedge clk);
        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle sequencer for the RV32M multiply/divide instructions (opcode 0110011, funct7 0000001) in the EX stage. It latches operands, runs a 32-iteration shift-add multiply or restoring divide, and holds the pipeline with `stall` until the result is ready. It sits beside the ALU and its control decode. Its result is muxed onto the EX result path in the cycle `done` is high.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- start  in  1  EX stage holds a valid M-extension instruction; held high until the cycle `done`=1.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value (forwarded).
- op_b  in  XLEN  rs2 value (forwarded).
- flush  in  1  EX instruction is squashed (branch/jump redirect).
- stall  out  1  freeze PC/IF/ID/EX pipeline registers.
- done  out  1  one-cycle pulse: `result` valid, pipeline may advance.
- result  out  XLEN  final value, registered.

## Operation
- States: IDLE, PREP, RUN, FIX, DONE. Internal state: 6-bit iteration counter, 64-bit accumulator/remainder pair, latched funct3, sign flags `neg_res` and `neg_rem`.
- **IDLE**, when `start`=1 and `flush`=0: latch funct3, op_a and op_b.
  - DIV/DIVU with op_b==0: go to DONE. Result is 0xFFFFFFFF.
  - REM/REMU with op_b==0: go to DONE. Result is op_a.
  - DIV with op_a==0x80000000 and op_b==0xFFFFFFFF: go to DONE. Result is 0x80000000.
  - REM with the same operands: go to DONE. Result is 0.
  - All other cases: go to PREP.
- **PREP**: replace each operand treated as signed and negative with its magnitude.
  - op_a is signed for MULH, MULHSU, DIV, REM. op_b is signed for MULH, DIV, REM.
  - Multiply: `neg_res` = sign_a XOR sign_b.
  - Divide: quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
  - Clear the counter. Go to RUN.
- **RUN**: 32 iterations, one per cycle, counter 0..31. Go to FIX after counter==31.
  - Multiply: unsigned shift-add into a 64-bit product.
  - Divide: restoring. Shift the remainder left, subtract the divisor, keep the result if it is non-negative, set the quotient bit.
- **FIX**: apply signs and pick the output; the value is written into `result`.
  - Multiply: negate the full 64-bit product if `neg_res`. MUL takes bits [31:0]; MULH, MULHSU, MULHU take bits [63:32].
  - Divide: negate the quotient/remainder per its sign flag.
  - Go to DONE.
- **DONE**: `done`=1. Go to IDLE unconditionally. `start` is ignored in this cycle; the pipeline advances on this edge.
- `stall` = (state==IDLE && start && !flush) || state in {PREP, RUN, FIX}. It is 0 in DONE and 0 while `rst`=1.
- **flush** in any state: go to IDLE next cycle. No `done`, `result` unchanged. flush has priority over start.
- All arithmetic is modulo 2^64 internally. Results are truncated to XLEN with no saturation.

## Timing
- Reset values: state IDLE, `done`=0, `result`=0, `stall`=0, counter 0.
- `rst` asserted in any state: all state returns to reset values on that edge. An in-flight operation is discarded.
- Normal op, `start` first seen in cycle T:
  - PREP at T+1, RUN at T+2..T+33, FIX at T+34, DONE at T+35.
  - `stall` is high in cycles T..T+34: 35 stall cycles.
- Special-case op (divide-by-zero, overflow): DONE at T+1, one stall cycle (T).
- Back-to-back ops: the second `start` is accepted in the cycle after DONE (IDLE). There is no dead cycle beyond DONE.
- `stall` depends combinationally on `start`/`flush` in IDLE only. All other outputs are registered.
- flush in cycle T+k (0≤k≤34): the FSM is IDLE at T+k+1, and `stall` drops in cycle T+k.

## Test plan
- MUL 7×(−3) (op_a=7, op_b=0xFFFFFFFD, funct3 000) → `stall` high 35 cycles, `done` at T+35, result=0xFFFFFFEB.
- MULH, MULHSU, MULHU with op_a=op_b=0x80000000 → results 0x40000000, 0xC0000000, 0x40000000 respectively.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; REMU → 1.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with `done` at T+1. DIV 0x80000000/−1 → 0x80000000 and REM → 0, each at T+1.
- Flush at RUN cycle 10 → `stall` low at once, no `done`, `result` unchanged. Next `start` one cycle later completes in 35 cycles.
- `rst` pulse during RUN → all outputs reset next edge. Back-to-back MUL then DIV → two `done` pulses 36 cycles apart.
